instr_encoder: RTL and testbench



---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 119 +++++++++++
 tb/tb_instr_encoder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// rtl/instr_encoder_if.sv - descriptor handshake and imem write port bundle
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  // descriptor channel
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [11:0]       in_imm;

  // instruction-memory write port
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // producer of descriptors, consumer of imem writes
  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  // the encoder itself
  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - RV32I descriptor encoder and sequential imem loader
module instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_BEQ = 3'd6;
  localparam logic [2:0] OP_ILL = 3'd7;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_cnt;
  logic              r_full;
  logic              r_err;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;

  logic              w_in_ready;
  logic              w_xfer;
  logic [12:0]       w_b;
  logic [31:0]       w_enc;

  // start blocks acceptance in the same cycle so a restart never races a descriptor
  assign w_in_ready = (r_state == S_LOAD) && !start;
  assign w_xfer     = bus.in_valid && w_in_ready;

  // branch offset is carried halved; restore the implicit zero LSB
  assign w_b = {bus.in_imm, 1'b0};

  // pack the descriptor into its RV32I format; unused fields are simply not referenced
  always_comb begin
    w_enc = 32'h0000_0000;
    case (bus.in_op)
      OP_LW:  w_enc = {bus.in_imm, bus.in_rs1, 3'b010, bus.in_rd, OPC_LOAD};
      OP_SW:  w_enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010,
                       bus.in_imm[4:0], OPC_STORE};
      OP_ADD: w_enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, OPC_OP};
      OP_SUB: w_enc = {7'b0100000, bus.in_rs2, bus.in_rs1, 3'b000, bus.in_rd, OPC_OP};
      OP_AND: w_enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b111, bus.in_rd, OPC_OP};
      OP_OR:  w_enc = {7'b0000000, bus.in_rs2, bus.in_rs1, 3'b110, bus.in_rd, OPC_OP};
      OP_BEQ: w_enc = {w_b[12], w_b[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                       w_b[4:1], w_b[11], OPC_BRANCH};
      default: w_enc = 32'h0000_0000;
    endcase
  end

  // load FSM: accept, register the write for the next cycle, track fill level and errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= 32'h0000_0000;
    end else begin
      r_we <= 1'b0;
      if (start) begin
        r_state <= S_LOAD;
        r_ptr   <= '0;
        r_cnt   <= '0;
        r_full  <= 1'b0;
        r_err   <= 1'b0;
      end else if (w_xfer) begin
        if (bus.in_op == OP_ILL) begin
          r_err <= 1'b1;
        end else begin
          r_we    <= 1'b1;
          r_addr  <= r_ptr;
          r_wdata <= w_enc;
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_cnt   <= r_cnt + (ADDR_W + 1)'(1);
          if (r_ptr == LAST_ADDR) begin
            r_full  <= 1'b1;
            r_state <= S_FULL;
          end
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign word_count     = r_cnt;
  assign full           = r_full;
  assign err            = r_err;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed checks of instr_encoder at DEPTH 64 and 4
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_op = 3'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [11:0] in_imm = 12'd0;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(6)) if64 ();
  instr_encoder_if #(.ADDR_W(2)) if4 ();

  logic [6:0] wc64;
  logic [2:0] wc4;
  logic       full64, full4, err64, err4;

  assign if64.in_valid = in_valid;
  assign if64.in_op    = in_op;
  assign if64.in_rd    = in_rd;
  assign if64.in_rs1   = in_rs1;
  assign if64.in_rs2   = in_rs2;
  assign if64.in_imm   = in_imm;
  assign if4.in_valid  = in_valid;
  assign if4.in_op     = in_op;
  assign if4.in_rd     = in_rd;
  assign if4.in_rs1    = in_rs1;
  assign if4.in_rs2    = in_rs2;
  assign if4.in_imm    = in_imm;

  instr_encoder #(.DEPTH(64)) dut64 (
    .clk(clk), .rst(rst), .start(start), .bus(if64),
    .word_count(wc64), .full(full64), .err(err64)
  );

  instr_encoder #(.DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .bus(if4),
    .word_count(wc4), .full(full4), .err(err4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // reference encoding built from field positions with plain arithmetic
  function automatic logic [31:0] ref_enc(input int op, input int rd, input int rs1,
                                          input int rs2, input int imm);
    int b;
    int f3;
    int f7;
    b = imm * 2;
    case (op)
      0: return 32'((imm << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 3);
      1: return 32'(((imm >> 5) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
                    + ((imm % 32) << 7) + 35);
      2, 3, 4, 5: begin
        f3 = (op == 4) ? 7 : (op == 5) ? 6 : 0;
        f7 = (op == 3) ? 32 : 0;
        return 32'((f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 51);
      end
      6: return 32'((((b >> 12) % 2) << 31) + (((b >> 5) % 64) << 25) + (rs2 << 20)
                    + (rs1 << 15) + (((b >> 1) % 16) << 8) + (((b >> 11) % 2) << 7) + 99);
      default: return 32'h0;
    endcase
  endfunction

  // behavioural model: a fill counter per memory, expected port values after each edge
  int          dep [2] = '{64, 4};
  int          m_cnt [2];
  logic        m_we [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic        m_err [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_err[k] = 0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit rdy;
      rdy = (m_cnt[k] != dep[k]) && !start;
      if (rst) begin
        m_cnt[k] = 0; m_we[k] = 0; m_addr[k] = 0; m_wdata[k] = 0; m_err[k] = 0;
      end else begin
        m_we[k] = 0;
        if (start) begin
          m_cnt[k] = 0;
          m_err[k] = 0;
        end else if (in_valid && rdy) begin
          if (in_op == 3'd7) begin
            m_err[k] = 1;
          end else begin
            m_we[k]    = 1;
            m_addr[k]  = 32'(m_cnt[k] % dep[k]);
            m_wdata[k] = ref_enc(int'(in_op), int'(in_rd), int'(in_rs1),
                                 int'(in_rs2), int'(in_imm));
            m_cnt[k]   = m_cnt[k] + 1;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] wc,
                          input logic fl, input logic er, input logic rdy);
    string p;
    p = (k == 0) ? "d64" : "d4";
    check({p, ".imem_we"},    32'(we),    32'(m_we[k]));
    check({p, ".imem_addr"},  addr,       m_addr[k]);
    check({p, ".imem_wdata"}, wdata,      m_wdata[k]);
    check({p, ".word_count"}, wc,         32'(m_cnt[k]));
    check({p, ".full"},       32'(fl),    32'(m_cnt[k] == dep[k]));
    check({p, ".err"},        32'(er),    32'(m_err[k]));
    check({p, ".in_ready"},   32'(rdy),   32'((m_cnt[k] != dep[k]) && !start));
  endtask

  // compare every cycle on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_inst(0, if64.imem_we, 32'(if64.imem_addr), if64.imem_wdata, 32'(wc64),
               full64, err64, if64.in_ready);
      cmp_inst(1, if4.imem_we, 32'(if4.imem_addr), if4.imem_wdata, 32'(wc4),
               full4, err4, if4.in_ready);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    in_valid = 1'b1;
    in_op    = 3'(op);
    in_rd    = 5'(rd);
    in_rs1   = 5'(rs1);
    in_rs2   = 5'(rs2);
    in_imm   = 12'(imm);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    step();
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [31:0] seq_exp [6] = '{32'h407302B3, 32'h00802083, 32'h00202223,
                               32'h0020F233, 32'h0020E233, 32'h00208463};

  initial begin
    // reset
    rst = 1'b1;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("rst.we", 32'(if64.imem_we), 32'd0);
    check("rst.wdata", if64.imem_wdata, 32'd0);
    check("rst.wc", 32'(wc64), 32'd0);
    check("rst.ready", 32'(if64.in_ready), 32'd1);

    // model encoder pinned to hand-computed words
    check("ref.add", ref_enc(2, 3, 1, 2, 0), 32'h002081B3);
    check("ref.beq_neg", ref_enc(6, 0, 0, 0, 12'hFFE), 32'hFE000EE3);
    check("ref.sw", ref_enc(1, 0, 0, 2, 4), 32'h00202223);

    // single ADD
    send(2, 3, 1, 2, 0);
    check("add.we", 32'(if64.imem_we), 32'd1);
    check("add.addr", 32'(if64.imem_addr), 32'd0);
    check("add.wdata", if64.imem_wdata, 32'h002081B3);
    check("add.wc", 32'(wc64), 32'd1);
    idle();

    // back-to-back mix
    pulse_start();
    send(3, 5, 6, 7, 0);
    check("seq0", if64.imem_wdata, seq_exp[0]);
    send(0, 1, 0, 0, 8);
    check("seq1", if64.imem_wdata, seq_exp[1]);
    send(1, 0, 0, 2, 4);
    check("seq2", if64.imem_wdata, seq_exp[2]);
    send(4, 4, 1, 2, 0);
    check("seq3", if64.imem_wdata, seq_exp[3]);
    send(5, 4, 1, 2, 0);
    check("seq4", if64.imem_wdata, seq_exp[4]);
    send(6, 0, 1, 2, 4);
    check("seq5", if64.imem_wdata, seq_exp[5]);
    check("seq5.addr", 32'(if64.imem_addr), 32'd5);
    check("seq5.we", 32'(if64.imem_we), 32'd1);
    idle();

    // negative offsets
    pulse_start();
    send(0, 1, 2, 0, 12'hFFC);
    check("lw_neg", if64.imem_wdata, 32'hFFC12083);
    send(6, 0, 0, 0, 12'hFFE);
    check("beq_neg", if64.imem_wdata, 32'hFE000EE3);
    idle();

    // illegal op between two ADDs
    pulse_start();
    send(2, 1, 2, 3, 0);
    send(7, 1, 2, 3, 0);
    check("ill.we", 32'(if64.imem_we), 32'd0);
    check("ill.err", 32'(err64), 32'd1);
    send(2, 1, 2, 3, 0);
    check("ill.addr2", 32'(if64.imem_addr), 32'd1);
    check("ill.err_sticky", 32'(err64), 32'd1);
    idle();

    // fill the DEPTH=4 memory with five descriptors
    pulse_start();
    for (int i = 0; i < 5; i++) send(2, i + 1, 1, 2, 0);
    check("fill.we", 32'(if4.imem_we), 32'd0);
    check("fill.wc", 32'(wc4), 32'd4);
    check("fill.full", 32'(full4), 32'd1);
    check("fill.ready", 32'(if4.in_ready), 32'd0);
    check("fill.addr", 32'(if4.imem_addr), 32'd3);
    start = 1'b1;
    #1;
    check("start.ready", 32'(if4.in_ready), 32'd0);
    step();
    start = 1'b0;
    check("start.full", 32'(full4), 32'd0);
    check("start.wc", 32'(wc4), 32'd0);
    check("start.we", 32'(if4.imem_we), 32'd0);
    send(4, 9, 1, 2, 0);
    check("restart.addr", 32'(if4.imem_addr), 32'd0);
    check("restart.we", 32'(if4.imem_we), 32'd1);

    // reset right after a transfer drops the pending write
    send(2, 7, 7, 7, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_mid.we", 32'(if64.imem_we), 32'd0);
    check("rst_mid.wc", 32'(wc64), 32'd0);
    check("rst_mid.wdata", if64.imem_wdata, 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 119) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_op    = ($urandom_range(0, 15) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      in_rd    = 5'($urandom);
      in_rs1   = 5'($urandom);
      in_rs2   = 5'($urandom);
      in_imm   = 12'($urandom);
      step();
    end
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
